// File: rtl/ring_entropy_harvester.sv
`default_nettype none
// ============================================================================
// Module      : ring_entropy_harvester
// Description : Samples a free-running ring-oscillator count once per window,
//               takes the LSB of each window delta as a raw bit, applies Von
//               Neumann debiasing and packs the kept bits into words offered
//               on a valid/ready port with stuck and overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_entropy_harvester #(
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 256,
  parameter int WORD_W    = 32,
  parameter int STUCK_LIM = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  cnt_in,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              overrun,
  output logic              stuck
);

  localparam int TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int ZR_W  = $clog2(STUCK_LIM + 1);

  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(WINDOW - 1);
  localparam logic [BC_W-1:0]  c_bc_last  = BC_W'(WORD_W - 1);
  localparam logic [ZR_W-1:0]  c_zr_lim   = ZR_W'(STUCK_LIM);

  // Von Neumann pairing state: waiting for first bit, or holding a 0 / 1
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD0 = 2'd1,
    S_HOLD1 = 2'd2
  } vn_state_t;

  // Window timer and sampling
  logic [TMR_W-1:0]  r_timer;
  logic [CNT_W-1:0]  r_prev_snap;
  logic              r_primed;
  logic              r_raw_vld;
  logic              r_raw_bit;
  logic [ZR_W-1:0]   r_zero_run;
  logic              w_terminal;
  logic [CNT_W-1:0]  w_delta;

  // Debiaser
  vn_state_t         r_vn_state;
  vn_state_t         w_vn_next;
  logic              w_kept_vld;
  logic              w_kept_bit;
  logic              r_kept_vld;
  logic              r_kept_bit;

  // Packer and output register
  logic [WORD_W-2:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WORD_W-1:0] w_word;
  logic              w_word_done;
  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              w_consume;

  assign w_terminal = enable && (r_timer == c_tmr_last);
  // Modulo subtraction makes counter wraparound transparent
  assign w_delta    = cnt_in - r_prev_snap;

  // Free-running window timer, held at zero while harvesting is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!enable || w_terminal) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Snapshot the counter at each window end, derive raw bit and zero-run count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_snap <= '0;
      r_primed    <= 1'b0;
      r_raw_vld   <= 1'b0;
      r_raw_bit   <= 1'b0;
      r_zero_run  <= '0;
    end else begin
      r_raw_vld <= 1'b0;
      if (!enable) begin
        r_primed   <= 1'b0;
        r_zero_run <= '0;
      end else if (w_terminal) begin
        r_prev_snap <= cnt_in;
        if (r_primed) begin
          r_raw_bit <= w_delta[0];
          r_raw_vld <= 1'b1;
          if (w_delta == '0) begin
            if (r_zero_run != c_zr_lim) begin
              r_zero_run <= r_zero_run + ZR_W'(1);
            end
          end else begin
            r_zero_run <= '0;
          end
        end else begin
          // First window only establishes a reference snapshot
          r_primed <= 1'b1;
        end
      end
    end
  end

  // Von Neumann state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vn_state <= S_EMPTY;
    end else begin
      r_vn_state <= w_vn_next;
    end
  end

  // Von Neumann pairing: differing pair keeps its first bit, equal pair is dropped
  always_comb begin
    w_vn_next  = r_vn_state;
    w_kept_vld = 1'b0;
    w_kept_bit = 1'b0;
    if (!enable) begin
      w_vn_next = S_EMPTY;
    end else if (r_raw_vld) begin
      case (r_vn_state)
        S_EMPTY: begin
          w_vn_next = r_raw_bit ? S_HOLD1 : S_HOLD0;
        end
        S_HOLD0: begin
          w_vn_next = S_EMPTY;
          if (r_raw_bit) begin
            w_kept_vld = 1'b1;
            w_kept_bit = 1'b0;
          end
        end
        S_HOLD1: begin
          w_vn_next = S_EMPTY;
          if (!r_raw_bit) begin
            w_kept_vld = 1'b1;
            w_kept_bit = 1'b1;
          end
        end
        default: begin
          w_vn_next = S_EMPTY;
        end
      endcase
    end
  end

  // Register the kept bit so packing happens one edge after debiasing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kept_vld <= 1'b0;
      r_kept_bit <= 1'b0;
    end else begin
      r_kept_vld <= w_kept_vld;
      r_kept_bit <= w_kept_bit;
    end
  end

  // First kept bit of a word ends up at the MSB
  assign w_word      = {r_shift, r_kept_bit};
  assign w_word_done = enable && r_kept_vld && (r_bit_cnt == c_bc_last);

  // Shift kept bits in and count them; a completed word restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (!enable) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_kept_vld) begin
      r_shift   <= w_word[WORD_W-2:0];
      r_bit_cnt <= w_word_done ? '0 : (r_bit_cnt + BC_W'(1));
    end
  end

  assign w_consume = r_valid && rnd_ready;

  // Output holding register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_word_done) begin
      if (!r_valid || w_consume) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else begin
        // Consumer still holds the old word: keep it, drop the new one
        r_overrun <= 1'b1;
      end
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign rnd_data  = r_data;
  assign rnd_valid = r_valid;
  assign overrun   = r_overrun;
  assign stuck     = (r_zero_run == c_zr_lim);

endmodule
`default_nettype wire

// File: tb/tb_ring_entropy_harvester.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_entropy_harvester
// Description : Self-checking bench for ring_entropy_harvester with a
//               window/pair/word level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_entropy_harvester;

  localparam int CNT_W     = 16;
  localparam int WINDOW    = 4;
  localparam int WORD_W    = 8;
  localparam int STUCK_LIM = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [CNT_W-1:0]  cnt_in;
  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              rnd_ready;
  logic              overrun;
  logic              stuck;

  ring_entropy_harvester #(
    .CNT_W    (CNT_W),
    .WINDOW   (WINDOW),
    .WORD_W   (WORD_W),
    .STUCK_LIM(STUCK_LIM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cnt_in   (cnt_in),
    .rnd_data (rnd_data),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .overrun  (overrun),
    .stuck    (stuck)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (window / pair / word level)
  logic [CNT_W-1:0]  m_prev;
  bit                m_primed;
  int                m_zero;
  bit                m_hold_v;
  bit                m_hold_b;
  logic [WORD_W-1:0] m_bits;
  int                m_nb;
  int                m_raw_cnt;
  int                m_win;
  bit                m_kb;
  bit                e_valid;
  logic [WORD_W-1:0] e_data;
  bit                e_overrun;
  int                sched_edge[$];
  logic [WORD_W-1:0] sched_word[$];
  int                e;

  // Observation helpers
  int                pulses;
  int                rise_edge;
  logic [WORD_W-1:0] last_word;
  bit                s_prev_valid;

  function automatic void model_flush();
    m_primed  = 1'b0;
    m_zero    = 0;
    m_hold_v  = 1'b0;
    m_hold_b  = 1'b0;
    m_bits    = '0;
    m_nb      = 0;
    m_raw_cnt = 0;
    m_win     = 0;
    sched_edge.delete();
    sched_word.delete();
  endfunction

  function automatic void model_reset();
    model_flush();
    m_prev    = '0;
    e_valid   = 1'b0;
    e_data    = '0;
    e_overrun = 1'b0;
  endfunction

  // One window end: raw bit from delta LSB, Von Neumann pairing, word packing
  function automatic void model_terminal(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] d;
    bit b;
    d      = c - m_prev;
    m_prev = c;
    m_win++;
    if (!m_primed) begin
      m_primed = 1'b1;
    end else begin
      b = d[0];
      m_raw_cnt++;
      if (d == 0) begin
        if (m_zero < STUCK_LIM) m_zero++;
      end else begin
        m_zero = 0;
      end
      if (!m_hold_v) begin
        m_hold_v = 1'b1;
        m_hold_b = b;
      end else begin
        m_hold_v = 1'b0;
        if (b != m_hold_b) begin
          m_bits = {m_bits[WORD_W-2:0], m_hold_b};
          m_nb++;
          if (m_nb == WORD_W) begin
            sched_edge.push_back(e + 2);
            sched_word.push_back(m_bits);
            m_nb = 0;
          end
        end
      end
    end
  endfunction

  // Counter value presented at a window end, by stimulus mode:
  // 0 random, 1 raw pairs (1,0), 2 odd deltas, 3 constant, 4 wrap table, 5 random pairs
  function automatic logic [CNT_W-1:0] pick_cnt(input int mode);
    bit b;
    logic [CNT_W-1:0] d;
    case (mode)
      1, 5: begin
        if (!m_primed) return CNT_W'($urandom);
        if (m_raw_cnt % 2 == 0) begin
          m_kb = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
          b    = m_kb;
        end else begin
          b = !m_kb;
        end
        d = {15'($urandom), b};
        return m_prev + d;
      end
      2: begin
        d = {15'($urandom), 1'b1};
        return m_prev + d;
      end
      3: return 16'h1234;
      4: begin
        case (m_win % 3)
          0:       return 16'hFFFE;
          1:       return 16'h0001;
          default: return 16'h0003;
        endcase
      end
      default: return CNT_W'($urandom);
    endcase
  endfunction

  // Reset, then enable; returns 1 time unit after a rising edge
  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    rnd_ready = 1'b0;
    cnt_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    enable       = 1'b1;
    e            = 0;
    s_prev_valid = 1'b0;
    pulses       = 0;
    rise_edge    = -1;
    last_word    = '0;
    model_reset();
  endtask

  // Drive nwin windows; rdy_mode 0 ready=1, 1 ready=0, 2 random
  task automatic run_stream(input int nwin, input int mode, input int rdy_mode);
    bit consume;
    bit loaded;
    for (int c = 0; c < nwin * WINDOW; c++) begin
      if ((e + 1) % WINDOW == 0) cnt_in = pick_cnt(mode);
      else                       cnt_in = CNT_W'($urandom);
      case (rdy_mode)
        0:       rnd_ready = 1'b1;
        1:       rnd_ready = 1'b0;
        default: rnd_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      e++;
      consume = e_valid && rnd_ready;
      loaded  = 1'b0;
      if (sched_edge.size() > 0 && sched_edge[0] == e) begin
        void'(sched_edge.pop_front());
        if (!e_valid || consume) begin
          e_data  = sched_word.pop_front();
          e_valid = 1'b1;
        end else begin
          void'(sched_word.pop_front());
          e_overrun = 1'b1;
        end
        loaded = 1'b1;
      end
      if (!loaded && consume) e_valid = 1'b0;
      if (e % WINDOW == 0) model_terminal(cnt_in);
      #1;
      n_cmp++;
      if (rnd_valid !== e_valid) begin
        n_bad++;
        $display("FAIL stream_valid edge %0d: got %b expected %b", e, rnd_valid, e_valid);
      end
      if (e_valid) begin
        n_cmp++;
        if (rnd_data !== e_data) begin
          n_bad++;
          $display("FAIL stream_data edge %0d: got %h expected %h", e, rnd_data, e_data);
        end
      end
      n_cmp++;
      if (overrun !== e_overrun) begin
        n_bad++;
        $display("FAIL stream_overrun edge %0d: got %b expected %b", e, overrun, e_overrun);
      end
      n_cmp++;
      if (stuck !== (m_zero == STUCK_LIM)) begin
        n_bad++;
        $display("FAIL stream_stuck edge %0d: got %b expected %b", e, stuck, (m_zero == STUCK_LIM));
      end
      if (rnd_valid === 1'b1 && !s_prev_valid) begin
        pulses++;
        rise_edge = e;
        last_word = rnd_data;
      end
      s_prev_valid = (rnd_valid === 1'b1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    run_stream(40, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
    n_cmp++;
    if (rnd_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h expected 00", rnd_data); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_cmp++;
    if (stuck !== 1'b0) begin n_bad++; $display("FAIL reset_stuck: got %b expected 0", stuck); end
    // Partial bits present before reset must never surface
    do_reset();
    run_stream(10, 1, 0);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL reset_partial: got %0d words expected 0", pulses); end
  endtask

  task automatic test_alternating();
    do_reset();
    run_stream(19, 1, 0);
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL alt_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if (last_word !== 8'hFF) begin n_bad++; $display("FAIL alt_word: got %h expected ff", last_word); end
    n_cmp++;
    if (rise_edge !== 17 * WINDOW + 2) begin
      n_bad++;
      $display("FAIL alt_latency: got edge %0d expected %0d", rise_edge, 17 * WINDOW + 2);
    end
  endtask

  task automatic test_all_odd();
    do_reset();
    run_stream(100, 2, 0);
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL odd_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_overrun();
    logic [WORD_W-1:0] first;
    do_reset();
    run_stream(36, 5, 1);
    first = last_word;
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    n_cmp++;
    if (rnd_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b expected 1", rnd_valid); end
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d expected 1", pulses); end
    run_stream(2, 5, 0);
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    n_cmp++;
    if (rnd_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_consumed: got %b expected 0", rnd_valid); end
    n_cmp++;
    if (last_word !== first) begin n_bad++; $display("FAIL ovr_word: got %h expected %h", last_word, first); end
  endtask

  task automatic test_stuck();
    do_reset();
    run_stream(5, 3, 0);
    n_cmp++;
    if (stuck !== 1'b1) begin n_bad++; $display("FAIL stuck_set: got %b expected 1", stuck); end
    enable = 1'b0;
    @(posedge clk);
    #1;
    model_flush();
    n_cmp++;
    if (stuck !== 1'b0) begin n_bad++; $display("FAIL stuck_disable: got %b expected 0", stuck); end
    n_cmp++;
    if (rnd_valid !== e_valid) begin n_bad++; $display("FAIL stuck_valid: got %b expected %b", rnd_valid, e_valid); end
    enable = 1'b1;
    e      = 0;
    run_stream(6, 0, 0);
  endtask

  task automatic test_counter_wrap();
    do_reset();
    run_stream(60, 4, 0);
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("FAIL wrap_pulses: got %0d expected 2", pulses); end
    n_cmp++;
    if (last_word !== 8'hAA) begin n_bad++; $display("FAIL wrap_word: got %h expected aa", last_word); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_stream(120, 0, 2);
    do_reset();
    run_stream(80, 5, 2);
    n_cmp++;
    if (pulses < 1) begin n_bad++; $display("FAIL b2b_words: got %0d expected at least 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_all_odd();
    test_overrun();
    test_stuck();
    test_counter_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
